// File: rtl/fwd_lkp_mc.sv
// -----------------------------------------------------------------------------
// fwd_lkp_mc : multi-channel forwarding lookup table
//
// Holds DEPTH = 2**AW entries of DW bits each. Two kinds of client share the
// single table port:
//   - the host CPU, over the squat bus, with a 4-phase Rdy_Dtack handshake
//   - NUM_LKP forwarding channels, through a round-robin req/gnt arbiter
// After reset an init sweep writes zero to every entry. Host cycles and
// lookups wait until the sweep is finished.
//
// Optional feature: define FWD_LKP_PARITY_EN to store one even-parity bit
// per entry. Lookups then flag a stored-parity mismatch on perr. When the
// macro is undefined, no parity is stored and perr is tied to 0.
//
// Ports
//   clk, rst_n            clock, asynchronous active-low reset
//   BusMode, Sel, Rd_DS,  host bus decode
//   Wr_RW, Addr, DataIn   (Addr[AW-1:0] used, the upper bits are ignored)
//   DataOut               host read data, held until the next host read
//   Rdy_Dtack             active-low host acknowledge
//   lkp_req / lkp_addr    per-channel lookup request and address
//   lkp_gnt               one-hot grant; the table is read in this cycle
//   lkp_vld / lkp_data    read data, one cycle after the grant
//   perr                  parity error, qualified by lkp_vld
//   init_done             high once the clear sweep has finished
//   dbg_state             current FSM state (0 INIT, 1 IDLE, 2 HACC, 3 HDONE)
//
// Lookup handshake: a channel raises lkp_req[i] with lkp_addr[i] stable and
// holds both until it sees lkp_gnt[i] high in a cycle. The table is read on
// the clock edge that ends that cycle. lkp_vld[i] pulses for one cycle after
// that edge. lkp_data[i] holds its value until the next lkp_vld[i].
// -----------------------------------------------------------------------------
`ifndef PORT_NUM
`define PORT_NUM 4
`endif

module fwd_lkp_mc #(
    parameter int AW      = 8,
    parameter int DW      = 12 + `PORT_NUM,
    parameter int NUM_LKP = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  BusMode,
    input  logic [11:0]           Addr,
    input  logic                  Sel,
    input  logic [DW-1:0]         DataIn,
    input  logic                  Rd_DS,
    input  logic                  Wr_RW,
    output logic [DW-1:0]         DataOut,
    output logic                  Rdy_Dtack,
    input  logic [NUM_LKP-1:0]    lkp_req,
    input  logic [NUM_LKP*AW-1:0] lkp_addr,
    output logic [NUM_LKP-1:0]    lkp_gnt,
    output logic [NUM_LKP-1:0]    lkp_vld,
    output logic [NUM_LKP*DW-1:0] lkp_data,
    output logic                  init_done,
    output logic [NUM_LKP-1:0]    perr,
    output logic [1:0]            dbg_state
);

    localparam int DEPTH = 1 << AW;
    localparam int RRW   = (NUM_LKP > 1) ? $clog2(NUM_LKP) : 1;
`ifdef FWD_LKP_PARITY_EN
    localparam int MW = DW + 1;   // parity bit stored above the data
`else
    localparam int MW = DW;
`endif

    typedef enum logic [1:0] {
        S_INIT  = 2'd0,
        S_IDLE  = 2'd1,
        S_HACC  = 2'd2,
        S_HDONE = 2'd3
    } state_t;

    // ---------------------------------------------------------------- state
    state_t                  state_q, state_d;
    logic [AW-1:0]           ptr_q, ptr_d;
    logic [RRW-1:0]          rr_q, rr_d;
    logic                    init_done_q, init_done_d;
    logic                    rdy_q, rdy_d;
    logic [DW-1:0]           dout_q, dout_d;
    logic [NUM_LKP-1:0]      vld_q, vld_d;
    logic [NUM_LKP*DW-1:0]   ldata_q, ldata_d;

    logic [MW-1:0]           table_mem [DEPTH];

    // ---------------------------------------------------------- host decode
    logic wr_cyc, rd_cyc, host_cyc, host_take, arb_en;
    logic unused_addr_bits;

    assign wr_cyc   = BusMode && ({Sel, Rd_DS, Wr_RW} == 3'b010);
    assign rd_cyc   = BusMode && ({Sel, Rd_DS, Wr_RW} == 3'b001);
    assign host_cyc = wr_cyc || rd_cyc;
    assign unused_addr_bits = ^Addr[11:AW];

    // The host owns the table only in the IDLE cycle that starts its access.
    // HACC and HDONE leave the port free, so a host cycle blocks lookups for
    // just that one cycle.
    assign host_take = (state_q == S_IDLE) && host_cyc;
    assign arb_en    = ((state_q == S_IDLE) && !host_cyc) ||
                       (state_q == S_HACC) || (state_q == S_HDONE);

    // -------------------------------------------------------------- arbiter
    logic               gnt_found;
    logic [RRW-1:0]     gnt_idx;
    logic [NUM_LKP-1:0] gnt;

    always_comb begin
        gnt_found = 1'b0;
        gnt_idx   = '0;
        gnt       = '0;
        if (arb_en) begin
            // Scan the channels starting at the round-robin pointer.
            for (int k = 0; k < NUM_LKP; k++) begin
                if (!gnt_found && lkp_req[(int'(rr_q) + k) % NUM_LKP]) begin
                    gnt_found = 1'b1;
                    gnt_idx   = RRW'((int'(rr_q) + k) % NUM_LKP);
                end
            end
        end
        if (gnt_found) begin
            gnt[gnt_idx] = 1'b1;
        end
    end

    // ----------------------------------------------------------- table port
    logic [AW-1:0] rd_addr;
    logic [MW-1:0] rd_word;
    logic [DW-1:0] rd_data;
    logic          tbl_we;
    logic [AW-1:0] tbl_waddr;
    logic [MW-1:0] tbl_wdata;
    logic [MW-1:0] host_wword;

    assign rd_addr = host_take ? Addr[AW-1:0]
                               : lkp_addr[int'(gnt_idx)*AW +: AW];
    assign rd_word = table_mem[rd_addr];
    assign rd_data = rd_word[DW-1:0];

`ifdef FWD_LKP_PARITY_EN
    assign host_wword = {^DataIn, DataIn};
`else
    assign host_wword = DataIn;
`endif

    always_ff @(posedge clk) begin
        if (tbl_we) begin
            table_mem[tbl_waddr] <= tbl_wdata;
        end
    end

    // ------------------------------------------------------ next-state logic
    always_comb begin
        state_d     = state_q;
        ptr_d       = ptr_q;
        init_done_d = init_done_q;
        rdy_d       = rdy_q;
        dout_d      = dout_q;
        tbl_we      = 1'b0;
        tbl_waddr   = Addr[AW-1:0];
        tbl_wdata   = host_wword;

        case (state_q)
            S_INIT: begin
                // An all-zero word also carries correct even parity.
                tbl_we    = 1'b1;
                tbl_waddr = ptr_q;
                tbl_wdata = '0;
                ptr_d     = ptr_q + AW'(1);
                if (ptr_q == '1) begin
                    state_d     = S_IDLE;
                    init_done_d = 1'b1;
                end
            end
            S_IDLE: begin
                if (host_cyc) begin
                    state_d = S_HACC;
                    if (wr_cyc) begin
                        tbl_we = 1'b1;
                    end else begin
                        dout_d = rd_data;
                    end
                end
            end
            S_HACC: begin
                // Acknowledge even if the decode has already dropped. A write
                // has committed by now in any case.
                rdy_d   = 1'b0;
                state_d = S_HDONE;
            end
            S_HDONE: begin
                if (!host_cyc) begin
                    rdy_d   = 1'b1;
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_INIT;
        endcase
    end

    always_comb begin
        rr_d    = rr_q;
        vld_d   = gnt;
        ldata_d = ldata_q;
        if (gnt_found) begin
            rr_d = (gnt_idx == RRW'(NUM_LKP - 1)) ? '0 : gnt_idx + RRW'(1);
        end
        for (int i = 0; i < NUM_LKP; i++) begin
            if (gnt[i]) begin
                ldata_d[i*DW +: DW] = rd_data;
            end
        end
    end

    // ------------------------------------------------------------ registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_INIT;
            ptr_q       <= '0;
            rr_q        <= '0;
            init_done_q <= 1'b0;
            rdy_q       <= 1'b1;
            dout_q      <= '0;
            vld_q       <= '0;
            ldata_q     <= '0;
        end else begin
            state_q     <= state_d;
            ptr_q       <= ptr_d;
            rr_q        <= rr_d;
            init_done_q <= init_done_d;
            rdy_q       <= rdy_d;
            dout_q      <= dout_d;
            vld_q       <= vld_d;
            ldata_q     <= ldata_d;
        end
    end

    // --------------------------------------------------------------- parity
`ifdef FWD_LKP_PARITY_EN
    logic [NUM_LKP-1:0] perr_q, perr_d;
    logic               par_bad;

    assign par_bad = rd_word[DW] ^ (^rd_data);

    always_comb begin
        perr_d = gnt & {NUM_LKP{par_bad}};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            perr_q <= '0;
        end else begin
            perr_q <= perr_d;
        end
    end

    assign perr = perr_q;
`else
    assign perr = '0;
`endif

    // -------------------------------------------------------------- outputs
    assign lkp_gnt   = gnt;
    assign lkp_vld   = vld_q;
    assign lkp_data  = ldata_q;
    assign DataOut   = dout_q;
    assign Rdy_Dtack = rdy_q;
    assign init_done = init_done_q;
    assign dbg_state = state_q;

endmodule
